// File: rtl/dfe_axil_master_arbiter.sv
// Two-requester AXI4-Lite master arbiter for the DataFreqExt register port.
// Round-robin grant in IDLE, one outstanding AXI4-Lite transaction at a time,
// single-cycle response pulse back to the owner, saturating error counter.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for a request; req_ready driven combinationally
// S_WR      | AWVALID/WVALID up, each dropped on its own handshake
// S_WR_RESP | BREADY up, waiting for BVALID
// S_RD_ADDR | ARVALID up, waiting for ARREADY
// S_RD_DATA | RREADY up, waiting for RVALID
// S_RSP     | rsp_valid pulse to the owning requester, then back to idle
module dfe_axil_master_arbiter #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                        ACLK,
  input  logic                        ARESET,
  input  logic [1:0]                  req_valid,
  output logic [1:0]                  req_ready,
  input  logic [1:0]                  req_write,
  input  logic [2*ADDR_WIDTH-1:0]     req_addr,
  input  logic [2*DATA_WIDTH-1:0]     req_wdata,
  input  logic [2*DATA_WIDTH/8-1:0]   req_wstrb,
  output logic [1:0]                  rsp_valid,
  output logic [DATA_WIDTH-1:0]       rsp_data,
  output logic [1:0]                  rsp_resp,
  output logic [ERR_CNT_WIDTH-1:0]    err_count,
  output logic [ADDR_WIDTH-1:0]       M_AXI_AWADDR,
  output logic [2:0]                  M_AXI_AWPROT,
  output logic                        M_AXI_AWVALID,
  input  logic                        M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]       M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0]     M_AXI_WSTRB,
  output logic                        M_AXI_WVALID,
  input  logic                        M_AXI_WREADY,
  input  logic [1:0]                  M_AXI_BRESP,
  input  logic                        M_AXI_BVALID,
  output logic                        M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0]       M_AXI_ARADDR,
  output logic [2:0]                  M_AXI_ARPROT,
  output logic                        M_AXI_ARVALID,
  input  logic                        M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0]       M_AXI_RDATA,
  input  logic [1:0]                  M_AXI_RRESP,
  input  logic                        M_AXI_RVALID,
  output logic                        M_AXI_RREADY
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_RSP
  } state_t;

  state_t                   state_q, state_d;
  logic                     last_q, last_d;
  logic                     gnt_q, gnt_d;
  logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]    wstrb_q, wstrb_d;
  logic                     awvalid_q, awvalid_d;
  logic                     wvalid_q, wvalid_d;
  logic                     bready_q, bready_d;
  logic                     arvalid_q, arvalid_d;
  logic                     rready_q, rready_d;
  logic [1:0]               rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]    rsp_data_q, rsp_data_d;
  logic [1:0]               rsp_resp_q, rsp_resp_d;
  logic [ERR_CNT_WIDTH-1:0] err_q, err_d;
  logic                     sel;
  logic                     any_req;

  // Next-state, arbitration and AXI channel sequencing.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = 2'b00;
    rsp_data_d  = rsp_data_q;
    rsp_resp_d  = rsp_resp_q;
    err_d       = err_q;
    req_ready   = 2'b00;
    any_req     = |req_valid;
    // On a conflict the requester that did not win last time gets the grant.
    sel         = (req_valid == 2'b11) ? ~last_q : req_valid[1];

    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          req_ready = sel ? 2'b10 : 2'b01;
          gnt_d     = sel;
          last_d    = sel;
          addr_d    = sel ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
          wdata_d   = sel ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
          wstrb_d   = sel ? req_wstrb[2*STRB_WIDTH-1:STRB_WIDTH] : req_wstrb[STRB_WIDTH-1:0];
          if (req_write[sel]) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = S_RD_ADDR;
          end
        end
      end
      S_WR: begin
        if (M_AXI_AWREADY) awvalid_d = 1'b0;
        if (M_AXI_WREADY)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = S_WR_RESP;
        end
      end
      S_WR_RESP: begin
        if (M_AXI_BVALID) begin
          bready_d    = 1'b0;
          rsp_data_d  = '0;
          rsp_resp_d  = M_AXI_BRESP;
          rsp_valid_d = gnt_q ? 2'b10 : 2'b01;
          state_d     = S_RSP;
        end
      end
      S_RD_ADDR: begin
        if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (M_AXI_RVALID) begin
          rready_d    = 1'b0;
          rsp_data_d  = M_AXI_RDATA;
          rsp_resp_d  = M_AXI_RRESP;
          rsp_valid_d = gnt_q ? 2'b10 : 2'b01;
          state_d     = S_RSP;
        end
      end
      S_RSP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Counted in the same edge the response is latched, so it is visible with rsp_valid.
    if ((rsp_valid_d != 2'b00) && (rsp_resp_d != 2'b00) && (err_q != '1))
      err_d = err_q + {{(ERR_CNT_WIDTH-1){1'b0}}, 1'b1};
  end

  // State and registered outputs; reset discards any in-flight transaction.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= S_IDLE;
      last_q      <= 1'b1;
      gnt_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 2'b00;
      rsp_data_q  <= '0;
      rsp_resp_q  <= 2'b00;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_resp_q  <= rsp_resp_d;
      err_q       <= err_d;
    end
  end

  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_resp      = rsp_resp_q;
  assign err_count     = err_q;

endmodule

// File: tb/tb_dfe_axil_master_arbiter.sv
// Bench for dfe_axil_master_arbiter: behavioural AXI4-Lite slave with
// programmable per-channel delays, a response scoreboard filled at request
// acceptance, and a linear sequence of directed scenarios.
module tb_dfe_axil_master_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int EW = 16;

  logic          ACLK = 1'b0;
  logic          ARESET = 1'b1;
  logic [1:0]    req_valid = 2'b00;
  logic [1:0]    req_ready;
  logic [1:0]    req_write;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [2*DW/8-1:0] req_wstrb;
  logic [1:0]    rsp_valid;
  logic [DW-1:0] rsp_data;
  logic [1:0]    rsp_resp;
  logic [EW-1:0] err_count;
  logic [AW-1:0] M_AXI_AWADDR, M_AXI_ARADDR;
  logic [2:0]    M_AXI_AWPROT, M_AXI_ARPROT;
  logic          M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY;
  logic          M_AXI_AWREADY = 1'b0, M_AXI_WREADY = 1'b0, M_AXI_BVALID = 1'b0;
  logic          M_AXI_ARREADY = 1'b0, M_AXI_RVALID = 1'b0;
  logic [DW-1:0] M_AXI_WDATA;
  logic [DW/8-1:0] M_AXI_WSTRB;
  logic [1:0]    M_AXI_BRESP = 2'b00, M_AXI_RRESP = 2'b00;
  logic [DW-1:0] M_AXI_RDATA = '0;

  // requester payloads
  logic          rq_wr    [2];
  logic [31:0]   rq_addr  [2];
  logic [31:0]   rq_wdata [2];
  logic [3:0]    rq_wstrb [2];
  assign req_write = {rq_wr[1], rq_wr[0]};
  assign req_addr  = {rq_addr[1], rq_addr[0]};
  assign req_wdata = {rq_wdata[1], rq_wdata[0]};
  assign req_wstrb = {rq_wstrb[1], rq_wstrb[0]};

  // slave configuration
  int          aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  bit          r_force = 1'b0;
  logic [31:0] r_force_data = '0;
  int          aw_hi = 0, w_hi = 0, b_hs_cnt = 0;

  typedef struct {
    int          id;
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;
  exp_t        sb[$];
  logic [31:0] ref_mem [16];
  logic [15:0] exp_err = '0;
  int          checks = 0;
  int          errors = 0;

  dfe_axil_master_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ERR_CNT_WIDTH(EW)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_resp(rsp_resp), .err_count(err_count),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected response for requester i, computed from the bench reference memory.
  task automatic push_exp(input int i);
    exp_t        e;
    logic [31:0] tmp;
    e.id = i;
    tmp  = ref_mem[rq_addr[i][5:2]];
    if (rq_wr[i]) begin
      for (int b = 0; b < 4; b++)
        if (rq_wstrb[i][b]) tmp[8*b +: 8] = rq_wdata[i][8*b +: 8];
      ref_mem[rq_addr[i][5:2]] = tmp;
      e.data = 32'h0;
      e.resp = bresp_cfg;
    end else begin
      e.data = r_force ? r_force_data : tmp;
      e.resp = rresp_cfg;
    end
    sb.push_back(e);
  endtask

  // Raise the requests in mask and hold each until accepted. Returns right after
  // the last acceptance edge (+2), with the first winner and its wait in cycles.
  task automatic issue(input logic [1:0] mask, input bit push, output int first, output int first_cyc);
    logic [1:0] pend;
    int         cyc;
    pend      = mask;
    cyc       = 0;
    first     = -1;
    first_cyc = -1;
    @(posedge ACLK); #2;
    req_valid = pend;
    while (pend != 2'b00 && cyc < 300) begin
      @(negedge ACLK);
      if (req_ready != 2'b00) begin
        chk("req_ready_legal", {63'b0, (req_ready == 2'b11) || ((req_ready & ~pend) != 2'b00)}, 64'd0);
        for (int i = 0; i < 2; i++) begin
          if (req_ready[i] && pend[i]) begin
            if (push) push_exp(i);
            if (first < 0) begin
              first     = i;
              first_cyc = cyc;
            end
            pend[i] = 1'b0;
          end
        end
      end
      @(posedge ACLK); #2;
      req_valid = pend;
      cyc++;
    end
    if (pend != 2'b00) chk("accept_timeout", {62'b0, pend}, 64'd0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge ACLK); #2;
      n++;
    end
    if (sb.size() != 0) chk("rsp_timeout", 64'(sb.size()), 64'd0);
    repeat (2) begin @(posedge ACLK); #2; end
  endtask

  // Response monitor: every rsp_valid pulse must match the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge ACLK);
      if (ARESET) exp_err = '0;
      else if (rsp_valid !== 2'b00) begin
        chk("rsp_not_both", {63'b0, rsp_valid == 2'b11}, 64'd0);
        if (sb.size() == 0) begin
          chk("rsp_unexpected", {62'b0, rsp_valid}, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("rsp_owner", {62'b0, rsp_valid}, (e.id == 1) ? 64'd2 : 64'd1);
          chk("rsp_data", {32'b0, rsp_data}, {32'b0, e.data});
          chk("rsp_resp", {62'b0, rsp_resp}, {62'b0, e.resp});
          if (e.resp != 2'b00 && exp_err != 16'hffff) exp_err = exp_err + 16'd1;
          chk("err_count", {48'b0, err_count}, {48'b0, exp_err});
        end
      end
    end
  end

  // Behavioural AXI4-Lite slave: handshakes are sampled mid-cycle, outputs
  // updated 1 time unit after the rising edge.
  initial begin
    logic [31:0] smem [16];
    logic        s_rst, s_aw_hs, s_w_hs, s_b_hs, s_ar_hs, s_r_hs, s_awv, s_wv, s_arv;
    logic [31:0] s_awaddr, s_wdata, s_araddr, waddr, wdat, raddr;
    logic [3:0]  s_wstrb, wstr;
    logic        got_aw, got_w, bpend, rpend;
    int          aw_wait, w_wait, bwait, ar_wait, rwait;
    for (int k = 0; k < 16; k++) smem[k] = '0;
    got_aw = 0; got_w = 0; bpend = 0; rpend = 0;
    aw_wait = 0; w_wait = 0; bwait = 0; ar_wait = 0; rwait = 0;
    waddr = '0; wdat = '0; wstr = '0; raddr = '0;
    forever begin
      @(negedge ACLK);
      s_rst    = ARESET;
      s_awv    = M_AXI_AWVALID;
      s_wv     = M_AXI_WVALID;
      s_arv    = M_AXI_ARVALID;
      s_aw_hs  = M_AXI_AWVALID && M_AXI_AWREADY;
      s_w_hs   = M_AXI_WVALID && M_AXI_WREADY;
      s_b_hs   = M_AXI_BVALID && M_AXI_BREADY;
      s_ar_hs  = M_AXI_ARVALID && M_AXI_ARREADY;
      s_r_hs   = M_AXI_RVALID && M_AXI_RREADY;
      s_awaddr = M_AXI_AWADDR;
      s_wdata  = M_AXI_WDATA;
      s_wstrb  = M_AXI_WSTRB;
      s_araddr = M_AXI_ARADDR;
      if (s_awv) aw_hi++;
      if (s_wv)  w_hi++;
      @(posedge ACLK); #1;
      if (s_rst) begin
        got_aw = 0; got_w = 0; bpend = 0; rpend = 0;
        aw_wait = 0; w_wait = 0; bwait = 0; ar_wait = 0; rwait = 0;
      end else begin
        if (s_aw_hs) begin got_aw = 1; waddr = s_awaddr; aw_wait = 0; end
        else if (s_awv) aw_wait++;
        if (s_w_hs) begin got_w = 1; wdat = s_wdata; wstr = s_wstrb; w_wait = 0; end
        else if (s_wv) w_wait++;
        if (s_b_hs) begin bpend = 0; b_hs_cnt++; end
        else if (bpend) bwait++;
        if (got_aw && got_w) begin
          for (int b = 0; b < 4; b++)
            if (wstr[b]) smem[waddr[5:2]][8*b +: 8] = wdat[8*b +: 8];
          got_aw = 0; got_w = 0; bpend = 1; bwait = 0;
        end
        if (s_r_hs) rpend = 0;
        else if (rpend) rwait++;
        if (s_ar_hs) begin rpend = 1; raddr = s_araddr; rwait = 0; ar_wait = 0; end
        else if (s_arv) ar_wait++;
      end
      M_AXI_AWREADY = M_AXI_AWVALID && !got_aw && (aw_wait >= aw_delay);
      M_AXI_WREADY  = M_AXI_WVALID && !got_w && (w_wait >= w_delay);
      M_AXI_BVALID  = bpend && (bwait >= b_delay);
      M_AXI_BRESP   = bresp_cfg;
      M_AXI_ARREADY = M_AXI_ARVALID && (ar_wait >= ar_delay);
      M_AXI_RVALID  = rpend && (rwait >= r_delay);
      M_AXI_RDATA   = r_force ? r_force_data : smem[raddr[5:2]];
      M_AXI_RRESP   = rresp_cfg;
    end
  end

  // Directed scenarios.
  initial begin
    int first, fcyc, base_aw, base_w, base_b, n;
    for (int k = 0; k < 16; k++) ref_mem[k] = '0;
    for (int i = 0; i < 2; i++) begin
      rq_wr[i] = 1'b0; rq_addr[i] = '0; rq_wdata[i] = '0; rq_wstrb[i] = '0;
    end

    // reset values
    repeat (3) begin @(posedge ACLK); #2; end
    chk("rst_req_ready", {62'b0, req_ready}, 64'd0);
    chk("rst_awvalid", {63'b0, M_AXI_AWVALID}, 64'd0);
    chk("rst_wvalid", {63'b0, M_AXI_WVALID}, 64'd0);
    chk("rst_bready", {63'b0, M_AXI_BREADY}, 64'd0);
    chk("rst_arvalid", {63'b0, M_AXI_ARVALID}, 64'd0);
    chk("rst_rready", {63'b0, M_AXI_RREADY}, 64'd0);
    chk("rst_rsp_valid", {62'b0, rsp_valid}, 64'd0);
    chk("rst_rsp_data", {32'b0, rsp_data}, 64'd0);
    chk("rst_rsp_resp", {62'b0, rsp_resp}, 64'd0);
    chk("rst_err_count", {48'b0, err_count}, 64'd0);
    chk("prot_tie", {58'b0, M_AXI_AWPROT, M_AXI_ARPROT}, 64'd0);
    ARESET = 1'b0;

    // single write then read back, zero-wait slave
    rq_wr[0] = 1'b1; rq_addr[0] = 32'h0; rq_wdata[0] = 32'h0101FFFF; rq_wstrb[0] = 4'hF;
    base_aw = aw_hi; base_w = w_hi;
    issue(2'b01, 1'b1, first, fcyc);
    chk("wr_awvalid_after_accept", {63'b0, M_AXI_AWVALID}, 64'd1);
    chk("wr_wvalid_after_accept", {63'b0, M_AXI_WVALID}, 64'd1);
    chk("wr_awaddr", {32'b0, M_AXI_AWADDR}, 64'h0);
    chk("wr_wdata", {32'b0, M_AXI_WDATA}, 64'h0101FFFF);
    wait_idle();
    chk("wr_aw_cycles", 64'(aw_hi - base_aw), 64'd1);
    chk("wr_w_cycles", 64'(w_hi - base_w), 64'd1);
    rq_wr[0] = 1'b0;
    issue(2'b01, 1'b1, first, fcyc);
    chk("rd_arvalid_after_accept", {63'b0, M_AXI_ARVALID}, 64'd1);
    wait_idle();

    // conflict after reset: req0 first, then req1; repeat also grants req0 first
    @(posedge ACLK); #2; ARESET = 1'b1;
    @(posedge ACLK); #2; ARESET = 1'b0;
    rq_wr[0] = 1'b1; rq_addr[0] = 32'h4; rq_wdata[0] = 32'habcd0001; rq_wstrb[0] = 4'hF;
    rq_wr[1] = 1'b1; rq_addr[1] = 32'h8; rq_wdata[1] = 32'hdead0011; rq_wstrb[1] = 4'hF;
    issue(2'b11, 1'b1, first, fcyc);
    chk("conflict1_first", 64'(first), 64'd0);
    wait_idle();
    rq_wr[0] = 1'b0; rq_wr[1] = 1'b0;
    issue(2'b11, 1'b1, first, fcyc);
    chk("conflict2_first", 64'(first), 64'd0);
    wait_idle();

    // independent AW/W: AWREADY held off 3 cycles, partial strobe
    aw_delay = 3;
    rq_wr[1] = 1'b1; rq_addr[1] = 32'hC; rq_wdata[1] = 32'h12345678; rq_wstrb[1] = 4'h3;
    base_aw = aw_hi; base_w = w_hi; base_b = b_hs_cnt;
    issue(2'b10, 1'b1, first, fcyc);
    wait_idle();
    chk("split_aw_cycles", 64'(aw_hi - base_aw), 64'd4);
    chk("split_w_cycles", 64'(w_hi - base_w), 64'd1);
    chk("split_b_handshakes", 64'(b_hs_cnt - base_b), 64'd1);
    aw_delay = 0;
    rq_wr[1] = 1'b0;
    issue(2'b10, 1'b1, first, fcyc);
    wait_idle();

    // read error with delayed RVALID
    r_delay = 5; r_force = 1'b1; r_force_data = 32'hbeef0011; rresp_cfg = 2'b10;
    rq_wr[0] = 1'b0; rq_addr[0] = 32'h10;
    issue(2'b01, 1'b1, first, fcyc);
    wait_idle();
    chk("rderr_err_count", {48'b0, err_count}, 64'd1);
    r_force = 1'b0; rresp_cfg = 2'b00;

    // reset while waiting in RD_DATA, then a normal req1 read
    r_delay = 40;
    rq_addr[0] = 32'h4;
    issue(2'b01, 1'b0, first, fcyc);
    n = 0;
    while (M_AXI_RREADY !== 1'b1 && n < 50) begin @(posedge ACLK); #2; n++; end
    chk("mid_rd_data_reached", {63'b0, M_AXI_RREADY}, 64'd1);
    repeat (2) begin @(posedge ACLK); #2; end
    ARESET = 1'b1;
    @(posedge ACLK); #2;
    ARESET = 1'b0;
    chk("mid_rst_rready", {63'b0, M_AXI_RREADY}, 64'd0);
    chk("mid_rst_arvalid", {63'b0, M_AXI_ARVALID}, 64'd0);
    chk("mid_rst_rsp_valid", {62'b0, rsp_valid}, 64'd0);
    chk("mid_rst_err_count", {48'b0, err_count}, 64'd0);
    r_delay = 0;
    rq_wr[1] = 1'b0; rq_addr[1] = 32'h4;
    issue(2'b10, 1'b1, first, fcyc);
    chk("post_rst_idle_grant", 64'(fcyc), 64'd0);
    wait_idle();
    repeat (10) begin @(posedge ACLK); #2; end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL sim_timeout: observed no completion expected completion before time limit");
    $fatal(1, "time limit");
  end

endmodule
